fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction fetch front end for the 5-stage RISC-V pipeline: issues word fetches to instruction memory,
//  buffers in-order responses with their PC in a small queue, presents {pc,inst} to IF/ID with valid/ready.
//  Absorbs variable imem latency, back-pressure (hazard stall) and redirects (taken branch/jump flush).
// PARAMETERS
//  XLEN      32  data/address width
//  DEPTH     4   queue entries; also max in-flight requests (power of 2, >=2)
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk            in   1     clock, all state on rising edge
//  rst_n          in   1     asynchronous, active-low reset
//  redirect_i     in   1     flush queue, restart fetch at redirect_pc_i
//  redirect_pc_i  in   XLEN  new fetch PC (word aligned)
//  imem_req_o     out  1     fetch request valid
//  imem_addr_o    out  XLEN  fetch address, stable while req high and not ready
//  imem_ready_i   in   1     memory accepts request this cycle
//  imem_rvalid_i  in   1     response valid (in request order)
//  imem_rdata_i   in   XLEN  response instruction
//  inst_valid_o   out  1     head entry valid
//  inst_o         out  XLEN  head instruction
//  pc_o           out  XLEN  head PC
//  inst_ready_i   in   1     consumer takes head (low = hazard stall)
// BEHAVIOUR
//  Reset: imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, pc_o=0; queue empty, outstanding=0,
//   drop_cnt=0, state=FETCH, fetch_pc=resp_pc=RESET_PC. Reset mid-operation discards everything.
//  credit = DEPTH - count - outstanding (never negative); responses can never overflow the queue.
//  FETCH: imem_req_o = (credit!=0) & ~redirect_i; imem_addr_o = fetch_pc.
//   Accept (req&ready): fetch_pc += 4 (mod 2^XLEN, wraps), outstanding += 1.
//   Response: push {resp_pc, rdata}, resp_pc += 4, outstanding -= 1. Accept+response same cycle: net 0.
//  FLUSH: imem_req_o=0; each rvalid discarded, drop_cnt -= 1; drop_cnt reaching 0 -> FETCH next cycle.
//  Redirect (highest priority, any state): queue cleared, fetch_pc=resp_pc=redirect_pc_i,
//   drop_cnt = outstanding - rvalid (response in redirect cycle is dropped); outstanding=0;
//   next state FLUSH if drop_cnt!=0 else FETCH. Pop in redirect cycle has no effect. Redirect in FLUSH reloads.
//  Output: inst_valid_o = ~empty; inst_o/pc_o = head; pop on inst_valid_o & inst_ready_i.
//   Push+pop same cycle legal in any occupancy; count unchanged. Stall holds head stable indefinitely.
//  Latency: request accept -> response N cycles (memory) -> inst_valid_o next cycle (1 cycle queue latency).
// CONFIGURATION
//  FETCHQ_BYPASS_EN defined: queue empty & rvalid & inst_ready_i & ~redirect_i -> response drives
//   inst_o/pc_o with inst_valid_o=1 same cycle, not written; otherwise as without.
//  Not defined: all responses go through the queue; min latency rvalid -> inst_valid_o = 1 cycle; outputs
//   purely registered.
// STRUCTURE
//  fetchq_pkg: fq_state_e {FETCH, FLUSH}; fq_entry_t {pc, inst}; FQ_PC_STEP=4.
//  Sub-module fetchq_fifo: DEPTH x fq_entry_t ring buffer, push/pop/clear, count, full/empty; wrap
//   of rd/wr pointers at DEPTH. Top holds FSM, counters, PCs, bypass mux.
// TESTING
//  Reset, ready=1, 1-cycle latency, inst_ready=1 -> fetches 0x0,0x4,0x8..; pc_o follows +4, no gaps.
//  inst_ready=0 for 10 cycles -> 4 entries queued, imem_req_o=0 once credit 0; head pc 0x0 held stable.
//  3 in flight, redirect to 0x100 -> next 3 rvalid dropped, req low until drained, first pc_o=0x100.
//  Redirect same cycle as rvalid with outstanding=1 -> drop_cnt=0, FETCH immediately, req at 0x100 next cycle.
//  fetch_pc=0xFFFFFFFC -> next fetch 0x00000000 (wrap).
//  BYPASS on: empty queue, rvalid, ready -> inst_valid_o same cycle; off: one cycle later.

Source files
------------

// File: rtl/fetchq_pkg.sv
// fetchq_pkg: shared types and constants for the instruction fetch queue
package fetchq_pkg;
   localparam int FQ_XLEN    = 32;
   localparam int FQ_PC_STEP = 4;
   typedef enum logic [0:0] {FETCH = 1'b0, FLUSH = 1'b1} fq_state_e;
   localparam logic [0:0] ST_FETCH = FETCH;
   localparam logic [0:0] ST_FLUSH = FLUSH;
   typedef struct packed {
      logic [FQ_XLEN-1:0] pc;
      logic [FQ_XLEN-1:0] inst;
   } fq_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: redirect, imem request/response and IF/ID handshake bundle.
//  master = fetch queue side, slave = core/memory side.
//  redirect_i/redirect_pc_i : flush and restart PC
//  imem_req_o/imem_addr_o/imem_ready_i : fetch request channel
//  imem_rvalid_i/imem_rdata_i : in-order fetch responses
//  inst_valid_o/inst_o/pc_o/inst_ready_i : queue head towards IF/ID
interface fetch_queue_if #(
   parameter int XLEN = 32
) ();
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_ready_i;
   logic            imem_rvalid_i;
   logic [XLEN-1:0] imem_rdata_i;
   logic            inst_valid_o;
   logic [XLEN-1:0] inst_o;
   logic [XLEN-1:0] pc_o;
   logic            inst_ready_i;
   modport master (
      input  redirect_i, redirect_pc_i, imem_ready_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
      output imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o
   );
   modport slave (
      output redirect_i, redirect_pc_i, imem_ready_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
      input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o
   );
endinterface

// File: rtl/fetchq_fifo.sv
// fetchq_fifo: DEPTH-entry ring buffer of {pc,inst} with push/pop/clear.
//  push_i/wdata_i : write entry; pop_i : drop head; clear_i : empty the buffer
//  rdata_o : head entry; count_o/full_o/empty_o : occupancy
module fetchq_fifo
   import fetchq_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          clear_i,
   input  fq_entry_t     wdata_i,
   output fq_entry_t     rdata_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);
   fq_entry_t     mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q;
   assign rdata_o = mem_q[rd_q];
   assign count_o = count_q;
   assign full_o  = count_q == CW'(DEPTH);
   assign empty_o = count_q == '0;
   // DEPTH is a power of two, so the pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '{default: '0};
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) mem_q[wr_q] <= wdata_i;
         wr_q    <= wr_q + AW'(push_i);
         rd_q    <= rd_q + AW'(pop_i);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: RISC-V fetch front end; issues word fetches, queues in-order responses with their PC,
//  presents {pc,inst} to IF/ID, and drops stale responses after a redirect.
//  clk, rst_n (async, active-low) ; bus : fetch_queue_if.master (see interface header)
//  Build option FETCHQ_BYPASS_EN: a response arriving at an empty queue with a ready consumer
//  is forwarded combinationally instead of being written.
module fetch_queue
   import fetchq_pkg::*;
#(
   parameter int              XLEN     = FQ_XLEN,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_queue_if.master bus
);
   localparam int              CW   = $clog2(DEPTH) + 1;
   localparam logic [XLEN-1:0] STEP = XLEN'(FQ_PC_STEP);
   logic [0:0]      state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
   logic [CW-1:0]   out_q, out_d, drop_q, drop_d;
   logic [CW-1:0]   count, credit;
   logic            empty, full, fetching, accept, rsp, push, pop, bypass;
   fq_entry_t       head, wdata;
   // Slots not yet claimed by queued entries or requests still in flight
   assign credit         = CW'(DEPTH) - count - out_q;
   assign fetching       = state_q == ST_FETCH;
   assign bus.imem_req_o = rst_n & fetching & (credit != '0) & ~bus.redirect_i;
   assign bus.imem_addr_o = fetch_pc_q;
   assign accept = bus.imem_req_o & bus.imem_ready_i;
   assign rsp    = fetching & bus.imem_rvalid_i & ~bus.redirect_i;
   assign pop    = ~empty & bus.inst_ready_i & ~bus.redirect_i;
   assign push   = rsp & ~bypass & (~full | pop);
   assign wdata  = '{pc: resp_pc_q, inst: bus.imem_rdata_i};
`ifdef FETCHQ_BYPASS_EN
   assign bypass           = empty & rsp & bus.inst_ready_i;
   assign bus.inst_valid_o = ~empty | bypass;
   assign bus.inst_o       = bypass ? bus.imem_rdata_i : head.inst;
   assign bus.pc_o         = bypass ? resp_pc_q : head.pc;
`else
   assign bypass           = 1'b0;
   assign bus.inst_valid_o = ~empty;
   assign bus.inst_o       = head.inst;
   assign bus.pc_o         = head.pc;
`endif
   // Redirect dominates: everything still owed by memory (in flight or already being
   // drained) minus a response arriving this cycle must be discarded in FLUSH.
   always_comb begin
      fetch_pc_d = bus.redirect_i ? bus.redirect_pc_i : fetch_pc_q + (accept ? STEP : '0);
      resp_pc_d  = bus.redirect_i ? bus.redirect_pc_i : resp_pc_q + (rsp ? STEP : '0);
      out_d      = bus.redirect_i ? '0 : out_q + CW'(accept) - CW'(rsp);
      drop_d     = bus.redirect_i ? out_q + drop_q - CW'(bus.imem_rvalid_i)
                 : fetching ? drop_q : drop_q - CW'(bus.imem_rvalid_i);
      state_d    = (bus.redirect_i | ~fetching) ? ((drop_d != '0) ? ST_FLUSH : ST_FETCH) : state_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_FETCH;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         out_q      <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
      end
   end
   fetchq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .clear_i (bus.redirect_i),
      .wdata_i (wdata),
      .rdata_o (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue with a latency-programmable imem model
module tb_fetch_queue;
`ifdef FETCHQ_BYPASS_EN
   localparam int BP = 1;
`else
   localparam int BP = 0;
`endif
   logic clk = 1'b0;
   logic rst_n;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int lat = 1;
   logic [31:0] addr_q [$];
   int due_q [$];
   fetch_queue_if #(.XLEN(32)) bus ();
   fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      logic acc, rv;
      logic [31:0] a;
      @(negedge clk);
      acc = bus.imem_req_o & bus.imem_ready_i;
      rv  = bus.imem_rvalid_i;
      a   = bus.imem_addr_o;
      @(posedge clk);
      cyc++;
      #1;
      if (rv && addr_q.size() > 0) begin
         void'(addr_q.pop_front());
         void'(due_q.pop_front());
      end
      if (acc) begin
         addr_q.push_back(a);
         due_q.push_back(cyc + lat - 1);
      end
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = '0;
      if (addr_q.size() > 0) begin
         if (due_q[0] <= cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = ~addr_q[0];
         end
      end
      #1;
   endtask
   task automatic do_reset(input int l, input logic iready);
      rst_n = 1'b0;
      lat = l;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = '0;
      bus.imem_ready_i  = 1'b1;
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = '0;
      bus.inst_ready_i  = iready;
      addr_q.delete();
      due_q.delete();
      #1;
      check("rst_req", {31'b0, bus.imem_req_o}, 32'h0);
      check("rst_addr", bus.imem_addr_o, 32'h0);
      check("rst_valid", {31'b0, bus.inst_valid_o}, 32'h0);
      check("rst_inst", bus.inst_o, 32'h0);
      check("rst_pc", bus.pc_o, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
   endtask
   task automatic wait_valid(input int max);
      int n = 0;
      while (!bus.inst_valid_o && n < max) begin
         tick();
         n++;
      end
      check("wait_valid", {31'b0, bus.inst_valid_o}, 32'h1);
   endtask
   initial begin
      // stall: consumer not ready, queue fills to DEPTH and fetching stops
      do_reset(1, 1'b0);
      check("first_req", {31'b0, bus.imem_req_o}, 32'h1);
      check("first_addr", bus.imem_addr_o, 32'h0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k >= 4) check("stall_req", {31'b0, bus.imem_req_o}, 32'h0);
         if (k >= 2) begin
            check("stall_valid", {31'b0, bus.inst_valid_o}, 32'h1);
            check("stall_pc", bus.pc_o, 32'h0);
            check("stall_inst", bus.inst_o, 32'hFFFF_FFFF);
         end
      end
      // release: queued 4,8,C drain, then continuous stream with no gaps
      bus.inst_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("stream_valid", {31'b0, bus.inst_valid_o}, 32'h1);
         check("stream_pc", bus.pc_o, 32'((i + 1) * 4));
         check("stream_inst", bus.inst_o, ~32'((i + 1) * 4));
      end
      // three requests in flight, redirect to 0x100
      do_reset(4, 1'b1);
      tick(); tick(); tick();
      check("inflight_req", {31'b0, bus.imem_req_o}, 32'h1);
      check("inflight_addr", bus.imem_addr_o, 32'hC);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h100;
      #1;
      check("redir_req_low", {31'b0, bus.imem_req_o}, 32'h0);
      tick();
      bus.redirect_i = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("flush_req", {31'b0, bus.imem_req_o}, 32'h0);
         check("flush_valid", {31'b0, bus.inst_valid_o}, 32'h0);
         tick();
      end
      check("refetch_req", {31'b0, bus.imem_req_o}, 32'h1);
      check("refetch_addr", bus.imem_addr_o, 32'h100);
      wait_valid(12);
      check("redir_pc", bus.pc_o, 32'h100);
      check("redir_inst", bus.inst_o, ~32'h100);
      // redirect coinciding with the only outstanding response
      do_reset(1, 1'b1);
      tick();
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h100;
      tick();
      bus.redirect_i = 1'b0;
      #1;
      check("same_req", {31'b0, bus.imem_req_o}, 32'h1);
      check("same_addr", bus.imem_addr_o, 32'h100);
      check("same_valid", {31'b0, bus.inst_valid_o}, 32'h0);
      wait_valid(8);
      check("same_pc", bus.pc_o, 32'h100);
      // fetch PC wraps past the top of the address space
      do_reset(1, 1'b1);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'hFFFF_FFFC;
      tick();
      bus.redirect_i = 1'b0;
      #1;
      check("wrap_req", {31'b0, bus.imem_req_o}, 32'h1);
      check("wrap_addr0", bus.imem_addr_o, 32'hFFFF_FFFC);
      tick();
      check("wrap_addr1", bus.imem_addr_o, 32'h0);
      wait_valid(8);
      check("wrap_pc0", bus.pc_o, 32'hFFFF_FFFC);
      tick();
      check("wrap_valid1", {31'b0, bus.inst_valid_o}, 32'h1);
      check("wrap_pc1", bus.pc_o, 32'h0);
      // response-to-valid latency: same cycle with bypass, one cycle without
      do_reset(1, 1'b1);
      tick();
      check("lat_valid0", {31'b0, bus.inst_valid_o}, 32'(BP));
      check("lat_pc0", bus.pc_o, 32'h0);
      tick();
      check("lat_valid1", {31'b0, bus.inst_valid_o}, 32'h1);
      check("lat_pc1", bus.pc_o, 32'(BP * 4));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
